// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and helpers for the program-memory port arbiter.
// Covers the arbiter FSM states and the word-index range check.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOCK = 2'd2
   } arb_state_e;

   // Byte-address LSBs dropped to form a word index
   localparam int WORD_OFFSET_W = 2;
   // Width used for the index-versus-depth comparison, wide enough for any ADDR_W
   localparam int IDX_CALC_W = 64;
   // Default depth of the 4 KB program memory, in words
   localparam int DEPTH_WORDS_DEF = 1024;

   function automatic logic idx_in_range(input logic [IDX_CALC_W-1:0] idx,
                                         input logic [IDX_CALC_W-1:0] depth);
      return (idx < depth);
   endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundles the fetch, loader, memory and CPU-hold signals around the arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface imem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              ld_req;
   logic              ld_we;
   logic              ld_last;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;

   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              cpu_hold;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ld_req, ld_we, ld_last, ld_addr, ld_wdata,
      output ld_gnt, ld_rvalid, ld_rdata,
      output mem_ce, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output cpu_hold
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ld_req, ld_we, ld_last, ld_addr, ld_wdata,
      input  ld_gnt, ld_rvalid, ld_rdata,
      input  mem_ce, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  cpu_hold
   );
endinterface

// File: rtl/imem_rsp_reg.sv
// One-cycle read response register: captures memory data at the grant edge,
// returning zero for out-of-range reads.
module imem_rsp_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture,
   input  logic              in_range,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);
   logic              rvalid_r;
   logic [DATA_W-1:0] rdata_r;

   // Response capture; rvalid is a single-cycle pulse per accepted read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_r <= 1'b0;
         rdata_r  <= {DATA_W{1'b0}};
      end else begin
         rvalid_r <= capture;
         if (capture) begin
            rdata_r <= in_range ? mem_rdata : {DATA_W{1'b0}};
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   assign rvalid = rvalid_r;
   assign rdata  = rdata_r;
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port program memory between CPU fetch and the loader:
// boot hold, fetch-priority arbitration, locked loader bursts and a starvation guard.
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int STARVE_MAX  = 4,
   parameter bit BOOT_LOAD   = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   imem_port_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam arb_state_e RST_STATE = BOOT_LOAD ? ST_BOOT : ST_RUN;

   arb_state_e state_r;
   arb_state_e state_nxt_s;
   logic [CNT_W-1:0] starve_r;
   logic [CNT_W-1:0] starve_nxt_s;
   logic cpu_hold_r;
   logic if_gnt_s;
   logic ld_gnt_s;
   logic starve_full_s;
   logic if_in_range_s;
   logic ld_in_range_s;
   logic sel_in_range_s;
   logic [ADDR_W-WORD_OFFSET_W-1:0] if_idx_s;
   logic [ADDR_W-WORD_OFFSET_W-1:0] ld_idx_s;

   assign if_idx_s      = bus.if_addr[ADDR_W-1:WORD_OFFSET_W];
   assign ld_idx_s      = bus.ld_addr[ADDR_W-1:WORD_OFFSET_W];
   assign if_in_range_s = idx_in_range(IDX_CALC_W'(if_idx_s), IDX_CALC_W'(DEPTH_WORDS));
   assign ld_in_range_s = idx_in_range(IDX_CALC_W'(ld_idx_s), IDX_CALC_W'(DEPTH_WORDS));
   assign starve_full_s = (starve_r == CNT_W'(STARVE_MAX));

   // State, starvation counter and CPU hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= RST_STATE;
         starve_r   <= {CNT_W{1'b0}};
         cpu_hold_r <= BOOT_LOAD;
      end else begin
         state_r    <= state_nxt_s;
         starve_r   <= starve_nxt_s;
         cpu_hold_r <= (state_nxt_s == ST_BOOT);
      end
   end

   // Grant selection, next state and starvation count
   always_comb begin
      if_gnt_s     = 1'b0;
      ld_gnt_s     = 1'b0;
      state_nxt_s  = state_r;
      starve_nxt_s = {CNT_W{1'b0}};
      case (state_r)
         ST_BOOT: begin
            ld_gnt_s = bus.ld_req;
            if (ld_gnt_s && bus.ld_last) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_BOOT;
            end
         end
         ST_RUN: begin
            // A saturated counter flips priority to the loader for one grant
            if (starve_full_s) begin
               ld_gnt_s = bus.ld_req;
               if_gnt_s = bus.if_req & ~bus.ld_req;
            end else begin
               if_gnt_s = bus.if_req;
               ld_gnt_s = bus.ld_req & ~bus.if_req;
            end
            if (ld_gnt_s) begin
               starve_nxt_s = {CNT_W{1'b0}};
               state_nxt_s  = bus.ld_last ? ST_RUN : ST_LOCK;
            end else if (bus.ld_req && !starve_full_s) begin
               starve_nxt_s = starve_r + CNT_W'(1);
               state_nxt_s  = ST_RUN;
            end else begin
               starve_nxt_s = starve_r;
               state_nxt_s  = ST_RUN;
            end
         end
         ST_LOCK: begin
            ld_gnt_s = bus.ld_req;
            if (ld_gnt_s && bus.ld_last) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_LOCK;
            end
         end
         default: begin
            state_nxt_s = RST_STATE;
         end
      endcase
   end

   // Memory port mux driven from whichever requester holds the grant
   always_comb begin
      bus.mem_wdata = bus.ld_wdata;
      if (ld_gnt_s) begin
         bus.mem_addr   = bus.ld_addr;
         sel_in_range_s = ld_in_range_s;
      end else begin
         bus.mem_addr   = bus.if_addr;
         sel_in_range_s = if_in_range_s;
      end
      if ((if_gnt_s || ld_gnt_s) && sel_in_range_s) begin
         bus.mem_ce = 1'b1;
         bus.mem_we = ld_gnt_s & bus.ld_we;
      end else begin
         bus.mem_ce = 1'b0;
         bus.mem_we = 1'b0;
      end
   end

   assign bus.if_gnt   = if_gnt_s;
   assign bus.ld_gnt   = ld_gnt_s;
   assign bus.cpu_hold = cpu_hold_r;

   imem_rsp_reg #(.DATA_W(DATA_W)) u_if_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (if_gnt_s),
      .in_range  (if_in_range_s),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (bus.if_rvalid),
      .rdata     (bus.if_rdata)
   );

   imem_rsp_reg #(.DATA_W(DATA_W)) u_ld_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (ld_gnt_s & ~bus.ld_we),
      .in_range  (ld_in_range_s),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (bus.ld_rvalid),
      .rdata     (bus.ld_rdata)
   );
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: boot load, starvation guard, locked burst,
// range handling, misaligned fetch and reset during a burst.
module tb_imem_port_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [31:0] mem_model [0:1023];

   imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   imem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .STARVE_MAX(4), .BOOT_LOAD(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External memory: combinational read, write on the rising edge
   assign bus.mem_rdata = mem_model[bus.mem_addr[11:2]];
   always @(posedge clk) begin
      if (bus.mem_ce && bus.mem_we) mem_model[bus.mem_addr[11:2]] <= bus.mem_wdata;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic ld_set(input logic req, input logic we, input logic last,
                         input logic [31:0] addr, input logic [31:0] data);
      bus.ld_req   = req;
      bus.ld_we    = we;
      bus.ld_last  = last;
      bus.ld_addr  = addr;
      bus.ld_wdata = data;
   endtask

   task automatic if_set(input logic req, input logic [31:0] addr);
      bus.if_req  = req;
      bus.if_addr = addr;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      if_set(1'b0, 32'h0);
      ld_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      check_value("rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
      check_value("rst_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
      check_value("rst_ld_rvalid", {31'd0, bus.ld_rvalid}, 32'd0);
      check_value("rst_if_rdata", bus.if_rdata, 32'h0);
      check_value("rst_ld_rdata", bus.ld_rdata, 32'h0);
      check_value("rst_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Boot load: two beats, fetch request must be ignored in BOOT
      if_set(1'b1, 32'h4);
      ld_set(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000f025);
      #1;
      check_value("boot1_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      check_value("boot1_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      check_value("boot1_mem_we", {31'd0, bus.mem_we}, 32'd1);
      @(negedge clk);
      ld_set(1'b1, 1'b1, 1'b1, 32'h4, 32'h241d1000);
      #1;
      check_value("boot2_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
      check_value("boot2_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      check_value("boot2_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      @(negedge clk);
      ld_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check_value("run_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
      check_value("run_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      check_value("run_mem_ce", {31'd0, bus.mem_ce}, 32'd1);
      @(negedge clk);
      #1;
      check_value("fetch4_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
      check_value("fetch4_rdata", bus.if_rdata, 32'h241d1000);
      check_value("fetch4_ld_rvalid", {31'd0, bus.ld_rvalid}, 32'd0);
      if_set(1'b0, 32'h0);
      @(negedge clk);
      #1;
      check_value("idle_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);

      // Starvation guard: loader wins every fifth cycle
      if_set(1'b1, 32'h0);
      ld_set(1'b1, 1'b1, 1'b1, 32'h8, 32'hcafe0008);
      for (int i = 0; i < 10; i++) begin
         #1;
         check_value($sformatf("starve_ld_gnt_%0d", i), {31'd0, bus.ld_gnt},
                     (i % 5 == 4) ? 32'd1 : 32'd0);
         check_value($sformatf("starve_if_gnt_%0d", i), {31'd0, bus.if_gnt},
                     (i % 5 == 4) ? 32'd0 : 32'd1);
         @(negedge clk);
      end
      if_set(1'b0, 32'h0);
      ld_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check_value("starve_mem_word2", mem_model[2], 32'hcafe0008);

      // Locked 3-beat burst: write, read, write; fetch waits until the end
      ld_set(1'b1, 1'b1, 1'b0, 32'h10, 32'h11111111);
      #1;
      check_value("burst1_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      @(negedge clk);
      if_set(1'b1, 32'h18);
      ld_set(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      #1;
      check_value("burst2_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      check_value("burst2_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      check_value("burst2_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
      @(negedge clk);
      ld_set(1'b1, 1'b1, 1'b1, 32'h18, 32'h33333333);
      #1;
      check_value("burst3_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      check_value("burst3_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      check_value("burst_rd_rvalid", {31'd0, bus.ld_rvalid}, 32'd1);
      check_value("burst_rd_rdata", bus.ld_rdata, 32'h241d1000);
      @(negedge clk);
      ld_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check_value("post_burst_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      check_value("post_burst_ld_rvalid", {31'd0, bus.ld_rvalid}, 32'd0);
      @(negedge clk);
      #1;
      check_value("post_burst_rdata", bus.if_rdata, 32'h33333333);

      // Out-of-range fetch and loader write
      if_set(1'b1, 32'h1000);
      #1;
      check_value("oor_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      check_value("oor_if_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
      @(negedge clk);
      if_set(1'b0, 32'h0);
      ld_set(1'b1, 1'b1, 1'b1, 32'h1000, 32'hdeadbeef);
      #1;
      check_value("oor_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
      check_value("oor_if_rdata", bus.if_rdata, 32'h0);
      check_value("oor_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      check_value("oor_ld_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
      check_value("oor_ld_mem_we", {31'd0, bus.mem_we}, 32'd0);
      @(negedge clk);
      ld_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_value("oor_mem_word0", mem_model[0], 32'h0000f025);

      // Misaligned fetch reads the containing word
      if_set(1'b1, 32'h7);
      #1;
      check_value("misal_mem_ce", {31'd0, bus.mem_ce}, 32'd1);
      @(negedge clk);
      if_set(1'b0, 32'h0);
      #1;
      check_value("misal_rdata", bus.if_rdata, 32'h241d1000);
      @(negedge clk);

      // Reset during LOCK beat 2 (a read), then a fresh boot burst
      ld_set(1'b1, 1'b1, 1'b0, 32'h20, 32'h20202020);
      @(negedge clk);
      ld_set(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      #1;
      check_value("lock_rst_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      ld_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check_value("lock_rst_ld_rvalid", {31'd0, bus.ld_rvalid}, 32'd0);
      check_value("lock_rst_ld_rdata", bus.ld_rdata, 32'h0);
      check_value("lock_rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      if_set(1'b1, 32'h28);
      ld_set(1'b1, 1'b1, 1'b0, 32'h24, 32'h24242424);
      #1;
      check_value("reboot1_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      check_value("reboot1_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      @(negedge clk);
      ld_set(1'b1, 1'b1, 1'b1, 32'h28, 32'h28282828);
      #1;
      check_value("reboot2_ld_gnt", {31'd0, bus.ld_gnt}, 32'd1);
      check_value("reboot2_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
      @(negedge clk);
      ld_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check_value("reboot_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
      check_value("reboot_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      @(negedge clk);
      if_set(1'b0, 32'h0);
      #1;
      check_value("reboot_fetch_rdata", bus.if_rdata, 32'h28282828);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
